// File: rtl/sdram_arb_pkg.sv
// Shared defaults and types for the two-port SDRAM arbiter and its read-ID FIFO.
package sdram_arb_pkg;

  localparam int ADDR_W_DEF    = 25;
  localparam int DATA_W_DEF    = 16;
  localparam int ID_FIFO_DEPTH = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  // Requester ID (0/1) to one-hot grant vector.
  function automatic logic [1:0] id_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rid_fifo.sv
// In-order FIFO of requester IDs for reads accepted by the controller but not yet returned.
module rid_fifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = ID_FIFO_DEPTH
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is only taken when a pop frees the slot that same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign full  = (count == (PTR_W + 1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_id;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one Avalon-style SDRAM controller port between two requesters,
// with in-order routing of read returns.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              iCLK,
  input  logic              iRST,

  input  logic              iREQ0_write,
  input  logic              iREQ0_read,
  input  logic [ADDR_W-1:0] iREQ0_address,
  input  logic [DATA_W-1:0] iREQ0_writedata,
  output logic              oREQ0_waitrequest,
  output logic [DATA_W-1:0] oREQ0_readdata,
  output logic              oREQ0_readdatavalid,

  input  logic              iREQ1_write,
  input  logic              iREQ1_read,
  input  logic [ADDR_W-1:0] iREQ1_address,
  input  logic [DATA_W-1:0] iREQ1_writedata,
  output logic              oREQ1_waitrequest,
  output logic [DATA_W-1:0] oREQ1_readdata,
  output logic              oREQ1_readdatavalid,

  output logic              oMEM_write,
  output logic              oMEM_read,
  output logic [ADDR_W-1:0] oMEM_address,
  output logic [DATA_W-1:0] oMEM_writedata,
  input  logic              iMEM_waitrequest,
  input  logic [DATA_W-1:0] iMEM_readdata,
  input  logic              iMEM_readdatavalid,

  output logic [1:0]        oGRANT,
  output logic              oERR,
  output logic              oDBG_STATE
);

  // Handshake: a command transfers on a cycle where oMEM_read or oMEM_write is high and
  // iMEM_waitrequest is low; the owner sees that same cycle as its waitrequest going low.
  // Read returns are valid only in the single cycle iMEM_readdatavalid is high.

  arb_state_t        state;
  logic              owner;
  logic              rr_ptr;

  logic              elig0;
  logic              elig1;
  logic              pick;
  logic              busy;
  logic              own_wr;
  logic              own_rd;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;
  logic              accept;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_head;

  // A read-only request is held off while no ID slot is free; writes never need one.
  assign elig0 = iREQ0_write | (iREQ0_read & ~fifo_full);
  assign elig1 = iREQ1_write | (iREQ1_read & ~fifo_full);
  assign pick  = (elig0 & elig1) ? rr_ptr : elig1;

  assign busy      = (state == ST_BUSY);
  assign own_wr    = owner ? iREQ1_write     : iREQ0_write;
  assign own_rd    = owner ? iREQ1_read      : iREQ0_read;
  assign own_addr  = owner ? iREQ1_address   : iREQ0_address;
  assign own_wdata = owner ? iREQ1_writedata : iREQ0_writedata;

  // Write wins when the owner raises both strobes.
  assign oMEM_write     = busy & own_wr & ~iRST;
  assign oMEM_read      = busy & own_rd & ~own_wr & ~iRST;
  assign oMEM_address   = own_addr;
  assign oMEM_writedata = own_wdata;

  assign accept    = (oMEM_write | oMEM_read) & ~iMEM_waitrequest;
  assign fifo_push = accept & oMEM_read;
  assign fifo_pop  = iMEM_readdatavalid & ~fifo_empty & ~iRST;

  assign oREQ0_waitrequest = ~(busy & ~owner & ~iMEM_waitrequest & ~iRST);
  assign oREQ1_waitrequest = ~(busy &  owner & ~iMEM_waitrequest & ~iRST);

  assign oREQ0_readdata      = iMEM_readdata;
  assign oREQ1_readdata      = iMEM_readdata;
  assign oREQ0_readdatavalid = fifo_pop & ~fifo_head;
  assign oREQ1_readdatavalid = fifo_pop &  fifo_head;

  assign oDBG_STATE = state;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state  <= ST_IDLE;
      owner  <= 1'b0;
      rr_ptr <= 1'b0;
      oGRANT <= 2'b00;
      oERR   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (elig0 | elig1) begin
            state  <= ST_BUSY;
            owner  <= pick;
            rr_ptr <= ~pick;
            oGRANT <= id_onehot(pick);
          end
        end
        ST_BUSY: begin
          // Owner abandoning its request mid-grant is a protocol violation.
          if (!(own_wr | own_rd)) begin
            state  <= ST_IDLE;
            oGRANT <= 2'b00;
            oERR   <= 1'b1;
          end else if (accept) begin
            state  <= ST_IDLE;
            oGRANT <= 2'b00;
          end
        end
        default: begin
          state  <= ST_IDLE;
          oGRANT <= 2'b00;
        end
      endcase
      if (iMEM_readdatavalid && fifo_empty) begin
        oERR <= 1'b1;
      end
    end
  end

  rid_fifo #(
    .DEPTH (ID_FIFO_DEPTH)
  ) u_rid_fifo (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .push    (fifo_push),
    .push_id (owner),
    .pop     (fifo_pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: directed scenarios with a command/return scoreboard.
module tb_sdram_port_arbiter;

  logic        iCLK = 1'b0;
  logic        rst;
  logic        req0_wr, req0_rd, req1_wr, req1_rd;
  logic [24:0] req0_addr, req1_addr;
  logic [15:0] req0_wdata, req1_wdata;
  logic        req0_wait, req1_wait;
  logic [15:0] req0_rdata, req1_rdata;
  logic        req0_rdv, req1_rdv;
  logic        mem_wr, mem_rd;
  logic [24:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_wait;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
  logic [1:0]  grant;
  logic        err;
  logic        dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // {write, read, grant, address, writedata}
  logic [44:0] exp_cmd_q[$];
  // {rdv1, rdv0, readdata0, readdata1}
  logic [33:0] exp_ret_q[$];
  // bench model of outstanding read owners, oldest first
  logic        model_id_q[$];
  logic [1:0]  grant_log[$];

  sdram_port_arbiter #(.ADDR_W(25), .DATA_W(16)) dut (
    .iCLK                (iCLK),
    .iRST                (rst),
    .iREQ0_write         (req0_wr),
    .iREQ0_read          (req0_rd),
    .iREQ0_address       (req0_addr),
    .iREQ0_writedata     (req0_wdata),
    .oREQ0_waitrequest   (req0_wait),
    .oREQ0_readdata      (req0_rdata),
    .oREQ0_readdatavalid (req0_rdv),
    .iREQ1_write         (req1_wr),
    .iREQ1_read          (req1_rd),
    .iREQ1_address       (req1_addr),
    .iREQ1_writedata     (req1_wdata),
    .oREQ1_waitrequest   (req1_wait),
    .oREQ1_readdata      (req1_rdata),
    .oREQ1_readdatavalid (req1_rdv),
    .oMEM_write          (mem_wr),
    .oMEM_read           (mem_rd),
    .oMEM_address        (mem_addr),
    .oMEM_writedata      (mem_wdata),
    .iMEM_waitrequest    (mem_wait),
    .iMEM_readdata       (mem_rdata),
    .iMEM_readdatavalid  (mem_rvalid),
    .oGRANT              (grant),
    .oERR                (err),
    .oDBG_STATE          (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 iCLK = ~iCLK;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int n, input logic wr, input logic rd,
                         input logic [24:0] a, input logic [15:0] d);
    if (n == 0) begin
      req0_wr = wr; req0_rd = rd; req0_addr = a; req0_wdata = d;
    end else begin
      req1_wr = wr; req1_rd = rd; req1_addr = a; req1_wdata = d;
    end
  endtask

  task automatic expect_cmd(input int n, input logic wr, input logic rd,
                            input logic [24:0] a, input logic [15:0] d);
    logic [1:0] oh;
    oh = (n == 0) ? 2'b01 : 2'b10;
    exp_cmd_q.push_back({wr, rd & ~wr, oh, a, d});
    if (rd && !wr) model_id_q.push_back(n[0]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Present one command, hold it until the DUT accepts it, then drop it.
  task automatic issue(input int n, input logic wr, input logic rd,
                       input logic [24:0] a, input logic [15:0] d);
    logic ok;
    ok = 1'b0;
    set_req(n, wr, rd, a, d);
    expect_cmd(n, wr, rd, a, d);
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      ok = (n == 0) ? ~req0_wait : ~req1_wait;
    end
    check("issue_accept", 64'(ok), 64'(1'b1));
    tick();
    set_req(n, 1'b0, 1'b0, a, d);
  endtask

  // Drive one read return for the current cycle and record what the model says should happen.
  task automatic drive_ret(input logic [15:0] d);
    logic id;
    mem_rvalid = 1'b1;
    mem_rdata  = d;
    if (model_id_q.size() > 0) begin
      id = model_id_q.pop_front();
      exp_ret_q.push_back({(id ? 2'b10 : 2'b01), d, d});
    end
  endtask

  task automatic ret(input logic [15:0] d);
    drive_ret(d);
    tick();
    mem_rvalid = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge iCLK) begin
    if (!rst) begin
      if ((mem_wr || mem_rd) && !mem_wait) begin
        if (exp_cmd_q.size() == 0) check("cmd_unexpected", 64'(1'b1), 64'(1'b0));
        else check("cmd", 64'({mem_wr, mem_rd, grant, mem_addr, mem_wdata}),
                   64'(exp_cmd_q.pop_front()));
      end
      if (req0_rdv || req1_rdv) begin
        if (exp_ret_q.size() == 0) check("ret_unexpected", 64'({req1_rdv, req0_rdv}), 64'(2'b00));
        else check("ret", 64'({req1_rdv, req0_rdv, req0_rdata, req1_rdata}),
                   64'(exp_ret_q.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  logic        acc5;
  logic [15:0] rdat [4];

  initial begin
    rst = 1'b1;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    mem_wait = 1'b0; mem_rdata = '0; mem_rvalid = 1'b0;
    tick();
    tick();
    // reset values while reset is held
    check("rst_state", 64'(dbg_state), 64'(1'b0));
    check("rst_grant", 64'(grant), 64'(2'b00));
    check("rst_err", 64'(err), 64'(1'b0));
    check("rst_waits", 64'({req1_wait, req0_wait}), 64'(2'b11));
    check("rst_rdv", 64'({req1_rdv, req0_rdv}), 64'(2'b00));
    check("rst_memrw", 64'({mem_wr, mem_rd}), 64'(2'b00));
    rst = 1'b0;
    tick();

    // single write from requester 0, one-cycle latency
    set_req(0, 1'b1, 1'b0, 25'h0000005, 16'hA5A5);
    expect_cmd(0, 1'b1, 1'b0, 25'h0000005, 16'hA5A5);
    check("w0_idle_first", 64'(mem_wr), 64'(1'b0));
    tick();
    check("w0_write", 64'(mem_wr), 64'(1'b1));
    check("w0_addr", 64'(mem_addr), 64'(25'h0000005));
    check("w0_data", 64'(mem_wdata), 64'(16'hA5A5));
    check("w0_wait", 64'(req0_wait), 64'(1'b0));
    check("w0_grant", 64'(grant), 64'(2'b01));
    tick();
    set_req(0, 1'b0, 1'b0, '0, '0);
    check("w0_back_idle", 64'({dbg_state, grant}), 64'(3'b000));

    // write and read raised together go out as a write only
    issue(1, 1'b1, 1'b1, 25'h0000007, 16'h1234);

    // continuous writes from both requesters alternate grants
    do_reset();
    set_req(0, 1'b1, 1'b0, 25'h10, 16'h1111);
    set_req(1, 1'b1, 1'b0, 25'h20, 16'h2222);
    for (int i = 0; i < 2; i++) begin
      expect_cmd(0, 1'b1, 1'b0, 25'h10, 16'h1111);
      expect_cmd(1, 1'b1, 1'b0, 25'h20, 16'h2222);
    end
    grant_log.delete();
    for (int i = 0; i < 8; i++) begin
      #1;
      if (mem_wr && !mem_wait) grant_log.push_back(grant);
      tick();
    end
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    check("rr_count", 64'(grant_log.size()), 64'(4));
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check("rr_grant", 64'(grant_log[i]), 64'((i % 2 == 0) ? 2'b01 : 2'b10));

    // requester 1 read stalled by the controller for three cycles
    mem_wait = 1'b1;
    set_req(1, 1'b0, 1'b1, 25'h33, 16'h0);
    expect_cmd(1, 1'b0, 1'b1, 25'h33, 16'h0);
    tick();
    for (int c = 1; c <= 3; c++) begin
      check("stall_read", 64'(mem_rd), 64'(1'b1));
      check("stall_addr", 64'(mem_addr), 64'(25'h33));
      check("stall_wait1", 64'(req1_wait), 64'(1'b1));
      tick();
    end
    mem_wait = 1'b0;
    #1;
    check("stall_accept", 64'({mem_rd, req1_wait}), 64'(2'b10));
    tick();
    set_req(1, 1'b0, 1'b0, '0, '0);
    ret(16'hBEEF);

    // fill the ID FIFO, then a fifth read must wait for a return
    issue(0, 1'b0, 1'b1, 25'h40, 16'h0);
    issue(1, 1'b0, 1'b1, 25'h41, 16'h0);
    issue(1, 1'b0, 1'b1, 25'h42, 16'h0);
    issue(0, 1'b0, 1'b1, 25'h43, 16'h0);
    set_req(0, 1'b0, 1'b1, 25'h60, 16'h0);
    expect_cmd(0, 1'b0, 1'b1, 25'h60, 16'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("read5_blocked", 64'({dbg_state, mem_rd}), 64'(2'b00));
      tick();
    end
    rdat[0] = 16'hD000; rdat[1] = 16'hD001; rdat[2] = 16'hD002; rdat[3] = 16'hD003;
    acc5 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (acc5) req0_rd = 1'b0;
      if (i < 4) drive_ret(rdat[i]);
      else mem_rvalid = 1'b0;
      #1;
      if (req0_rd && !req0_wait) acc5 = 1'b1;
      tick();
    end
    mem_rvalid = 1'b0;
    req0_rd = 1'b0;
    check("read5_issued", 64'(acc5), 64'(1'b1));
    ret(16'hD004);

    // owner drops its request while granted
    do_reset();
    mem_wait = 1'b1;
    set_req(1, 1'b0, 1'b1, 25'h44, 16'h0);
    tick();
    check("drop_busy", 64'(dbg_state), 64'(1'b1));
    set_req(1, 1'b0, 1'b0, '0, '0);
    tick();
    check("drop_idle", 64'({dbg_state, grant}), 64'(3'b000));
    check("drop_err", 64'(err), 64'(1'b1));
    mem_wait = 1'b0;

    // read return with nothing outstanding
    do_reset();
    check("empty_err_clr", 64'(err), 64'(1'b0));
    mem_rvalid = 1'b1; mem_rdata = 16'hDEAD;
    #1;
    check("empty_no_rdv", 64'({req1_rdv, req0_rdv}), 64'(2'b00));
    tick();
    mem_rvalid = 1'b0;
    check("empty_err", 64'(err), 64'(1'b1));
    repeat (3) tick();
    check("empty_err_sticky", 64'(err), 64'(1'b1));

    // reset while busy with two reads outstanding
    do_reset();
    issue(0, 1'b0, 1'b1, 25'h50, 16'h0);
    issue(1, 1'b0, 1'b1, 25'h51, 16'h0);
    mem_wait = 1'b1;
    set_req(0, 1'b1, 1'b0, 25'h52, 16'h5252);
    tick();
    check("mid_busy", 64'(dbg_state), 64'(1'b1));
    rst = 1'b1;
    tick();
    check("mid_rst_state", 64'({dbg_state, grant, err}), 64'(4'b0000));
    check("mid_rst_waits", 64'({req1_wait, req0_wait}), 64'(2'b11));
    check("mid_rst_memrw", 64'({mem_wr, mem_rd}), 64'(2'b00));
    check("mid_rst_rdv", 64'({req1_rdv, req0_rdv}), 64'(2'b00));
    model_id_q.delete();
    set_req(0, 1'b0, 1'b0, '0, '0);
    mem_wait = 1'b0;
    rst = 1'b0;
    tick();
    mem_rvalid = 1'b1; mem_rdata = 16'hCAFE;
    #1;
    check("post_rst_no_rdv", 64'({req1_rdv, req0_rdv}), 64'(2'b00));
    tick();
    mem_rvalid = 1'b0;
    check("post_rst_err", 64'(err), 64'(1'b1));

    tick();
    check("cmd_q_drained", 64'(exp_cmd_q.size()), 64'(0));
    check("ret_q_drained", 64'(exp_ret_q.size()), 64'(0));

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 25, SDRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, SDRAM data width.
REQ-003 SHALL have port iCLK  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port iRST  in  1  reset, synchronous, active-high.
REQ-005 SHALL have, per requester n in {0,1}: iREQn_write in 1; iREQn_read in 1; iREQn_address in ADDR_W; iREQn_writedata in DATA_W; oREQn_waitrequest out 1; oREQn_readdata out DATA_W; oREQn_readdatavalid out 1.
REQ-006 SHALL have controller-side ports: oMEM_write out 1; oMEM_read out 1; oMEM_address out ADDR_W; oMEM_writedata out DATA_W; iMEM_waitrequest in 1; iMEM_readdata in DATA_W; iMEM_readdatavalid in 1.
REQ-007 SHALL have status ports: oGRANT out 2, one-hot current owner, 0 when idle; oERR out 1, sticky protocol error.

Function
REQ-008 SHALL implement a two-state FSM, IDLE and BUSY, plus an owner register and a round-robin pointer.
REQ-009 SHALL treat requester n as requesting when iREQn_write or iREQn_read is high; both high SHALL be forwarded as a write only.
REQ-010 In IDLE with one eligible requester, SHALL register that requester as owner and enter BUSY on the next edge.
REQ-011 In IDLE with both requesters eligible, SHALL grant the requester not granted last; the pointer then SHALL favour the other requester.
REQ-012 In BUSY, SHALL drive oMEM_* combinationally from the owner's inputs; oMEM_read and oMEM_write SHALL be 0 in IDLE.
REQ-013 oREQn_waitrequest SHALL be low only when n owns the grant, the state is BUSY, and iMEM_waitrequest is low; otherwise it SHALL be high.
REQ-014 A command SHALL be accepted on a cycle with BUSY, oMEM_read or oMEM_write high, and iMEM_waitrequest low; the FSM SHALL then return to IDLE.
REQ-015 Minimum latency from request to acceptance SHALL be 1 cycle; back-to-back commands SHALL be separated by at least 1 IDLE cycle.
REQ-016 If the owner deasserts its request while in BUSY, the FSM SHALL return to IDLE on the next edge, issue no command, and set oERR.
REQ-017 On each accepted read, SHALL push the owner ID into a 4-entry in-order ID FIFO.
REQ-018 When the ID FIFO is full, a requester presenting a read SHALL be ineligible; writes SHALL remain eligible.
REQ-019 On iMEM_readdatavalid, SHALL pop the FIFO head and assert that requester's oREQn_readdatavalid for exactly that cycle; oREQn_readdata SHALL equal iMEM_readdata for both requesters at all times.
REQ-020 A simultaneous push and pop SHALL keep the occupancy unchanged and preserve order.
REQ-021 iMEM_readdatavalid while the FIFO is empty SHALL be dropped, with no readdatavalid to either requester, and SHALL set oERR.
REQ-022 oERR SHALL clear only on reset.

Reset
REQ-023 While iRST is high, SHALL hold: state IDLE; owner none; oGRANT 0; pointer favouring requester 0; FIFO empty; oERR 0; oMEM_read and oMEM_write 0; both oREQn_waitrequest 1; both oREQn_readdatavalid 0.
REQ-024 Reset asserted mid-command or with reads outstanding SHALL discard all state; read returns arriving after reset SHALL be handled per REQ-021.

Structure
REQ-025 Package sdram_arb_pkg SHALL hold ADDR_W/DATA_W defaults, the FSM state type, and ID_FIFO_DEPTH=4.
REQ-026 The ID FIFO SHALL be sub-module rid_fifo, 1-bit wide and 4 entries deep, with push, pop, full, empty and head outputs.

Verification
REQ-027 Stimulus: only requester 0 writes address 0x0000005, data 0xA5A5, with iMEM_waitrequest low. Required: oMEM_write high one cycle later with those values, oREQ0_waitrequest low that cycle, then IDLE.
REQ-028 Stimulus: both requesters write continuously with iMEM_waitrequest low. Required: grants alternate 0,1,0,1.
REQ-029 Stimulus: requester 1 reads with iMEM_waitrequest high for 3 cycles. Required: oMEM_read and oMEM_address stay stable, oREQ1_waitrequest stays high, and the command is accepted on cycle 4.
REQ-030 Stimulus: 4 reads (0,1,1,0) accepted with no return, then a 5th read. Required: the 5th read is blocked; returns D0..D3 route to requesters 0,1,1,0, after which the 5th read issues.
REQ-031 Stimulus: iMEM_readdatavalid with the FIFO empty. Required: no requester readdatavalid, oERR=1 until iRST.
REQ-032 Stimulus: iRST pulsed while BUSY with 2 reads outstanding. Required: the REQ-023 values on the next cycle.
